// File: rtl/fma_dot_sequencer.sv
//------------------------------------------------------------------------------
// fma_dot_sequencer
//
// Purpose:
//   Initiator-side controller for an external combinational fused multiply-add
//   unit (z = a*b + c, DW status layout). Operand pairs arrive over a
//   valid/ready stream. Each accepted pair is issued as one FMA operation, with
//   the running accumulator fed back as c. When the programmed number of pairs
//   has been consumed, the final accumulator and its sticky status are
//   presented on a valid/ready result port. This block does no arithmetic; all
//   floating-point math happens in the FMA attached to the fma_* ports.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           begin a new dot product (sampled only while idle)
//   len             number of operand pairs (latched on start)
//   init_c          initial accumulator value (latched on start)
//   rnd             rounding mode (latched on start)
//   busy            high while running or while holding a result
//   in_valid/ready  operand-pair handshake; in_a, in_b are the operands
//   fma_a/b/c/rnd   operands and rounding mode driven to the FMA
//   fma_z/status    combinational FMA result and its status flags
//   out_valid/ready result handshake
//   out_z           final accumulator
//   out_status      sticky status {compspecific, hugeint, inexact, huge,
//                   tiny, invalid, infinity, zero}
//   out_count       number of pairs processed
//------------------------------------------------------------------------------
module fma_dot_sequencer #(
   parameter int SIG_WIDTH = 23,
   parameter int EXP_WIDTH = 8,
   parameter int LEN_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [LEN_WIDTH-1:0]           len,
   input  logic [SIG_WIDTH+EXP_WIDTH:0]   init_c,
   input  logic [2:0]                     rnd,
   output logic                           busy,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [SIG_WIDTH+EXP_WIDTH:0]   in_a,
   input  logic [SIG_WIDTH+EXP_WIDTH:0]   in_b,
   output logic [SIG_WIDTH+EXP_WIDTH:0]   fma_a,
   output logic [SIG_WIDTH+EXP_WIDTH:0]   fma_b,
   output logic [SIG_WIDTH+EXP_WIDTH:0]   fma_c,
   output logic [2:0]                     fma_rnd,
   input  logic [SIG_WIDTH+EXP_WIDTH:0]   fma_z,
   input  logic [7:0]                     fma_status,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [SIG_WIDTH+EXP_WIDTH:0]   out_z,
   output logic [7:0]                     out_status,
   output logic [LEN_WIDTH-1:0]           out_count
);

   localparam int W = SIG_WIDTH + EXP_WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // True when the magnitude (everything except the sign bit) is zero,
   // i.e. the value is +0 or -0.
   function automatic logic mag_is_zero(input logic [W-1:0] v);
      return (v[W-2:0] == {(W-1){1'b0}});
   endfunction

   state_e                state_q,     state_d;
   logic [W-1:0]          acc_q,       acc_d;
   logic [LEN_WIDTH-1:0]  cnt_q,       cnt_d;
   logic [7:0]            sticky_q,    sticky_d;
   logic [2:0]            rnd_q,       rnd_d;
   logic [LEN_WIDTH-1:0]  len_q,       len_d;
   logic                  out_valid_q, out_valid_d;
   logic                  busy_q,      busy_d;

   logic                  accept_s;
   logic [LEN_WIDTH:0]    cnt_inc_s;
   logic                  last_s;

   // Pair handshake and end-of-vector detection. The increment is one bit
   // wider than the counter so a maximal len cannot wrap before the compare.
   assign accept_s  = in_valid && (state_q == S_RUN);
   assign cnt_inc_s = {1'b0, cnt_q} + {{LEN_WIDTH{1'b0}}, 1'b1};
   assign last_s    = (cnt_inc_s == {1'b0, len_q});

   // Next-state and datapath update logic.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      rnd_d    = rnd_q;
      len_d    = len_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d = init_c;
               rnd_d = rnd;
               len_d = len;
               cnt_d = {LEN_WIDTH{1'b0}};
               if (len == {LEN_WIDTH{1'b0}}) begin
                  // Empty vector: the result is init_c itself, so its zero
                  // flag is derived here rather than by the FMA.
                  sticky_d = {7'b000_0000, mag_is_zero(init_c)};
                  state_d  = S_DONE;
               end else begin
                  sticky_d = 8'h00;
                  state_d  = S_RUN;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (accept_s) begin
               acc_d    = fma_z;
               cnt_d    = cnt_inc_s[LEN_WIDTH-1:0];
               // Exception flags accumulate; the zero flag describes only
               // the latest result.
               sticky_d = {sticky_q[7:1] | fma_status[7:1], fma_status[0]};
               if (last_s) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            // start is deliberately not looked at here; no queueing.
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         acc_q       <= {W{1'b0}};
         cnt_q       <= {LEN_WIDTH{1'b0}};
         sticky_q    <= 8'h00;
         rnd_q       <= 3'd0;
         len_q       <= {LEN_WIDTH{1'b0}};
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sticky_q    <= sticky_d;
         rnd_q       <= rnd_d;
         len_q       <= len_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   // FMA operands are always driven; their value only matters while running.
   assign fma_a   = in_a;
   assign fma_b   = in_b;
   assign fma_c   = acc_q;
   assign fma_rnd = rnd_q;

   assign in_ready   = (state_q == S_RUN);
   assign busy       = busy_q;
   assign out_valid  = out_valid_q;
   assign out_z      = acc_q;
   assign out_status = sticky_q;
   assign out_count  = cnt_q;

endmodule
